// File: rtl/sega_joy_reader.sv
// sega_joy_reader: free-running Sega pad scanner for two DB9 ports, one atomic 12-bit word per port.
// Define SEGA_JOY_SIXBUTTON_EN to enable the 6-button STEP2..STEP6 extension.
module sega_joy_reader #(
   parameter int STEP_DIV   = 400,
   parameter int IDLE_STEPS = 120
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [5:0]  joy1_i,
   input  logic [5:0]  joy2_i,
   output logic        joy_sel_o,
   output logic [11:0] joy1_o,
   output logic [11:0] joy2_o,
   output logic        joy1_md_o,
   output logic        joy2_md_o,
   output logic        joy1_six_o,
   output logic        joy2_six_o,
   output logic        frame_o
);
   localparam int DW = $clog2(STEP_DIV);
   localparam int IW = $clog2(IDLE_STEPS + 1);
   typedef enum logic [2:0] {STEP0, STEP1, STEP2, STEP3, STEP4, STEP5, STEP6, IDLE} state_t;
`ifdef SEGA_JOY_SIXBUTTON_EN
   localparam state_t PUB = STEP6;
`else
   localparam state_t PUB = STEP1;
`endif
   state_t st, nxt;
   logic [DW-1:0] div;
   logic [IW-1:0] idle_cnt;
   logic [5:0] j1_m, j1_s, j2_m, j2_s;
   logic [13:0] sc1, sc2, n1, n2;
   logic step_end, idle_done;
   // Scratch layout is {six, md, word[11:0]}; STEP0 clears the 6-button part.
   function automatic logic [13:0] scan(state_t s, logic [13:0] c, logic [5:0] p);
      logic [13:0] r;
      r = c;
      case (s)
         STEP0: r = {1'b0, 1'b0, 4'hF, 2'b11, p};
         STEP1: begin
            r[12] = ~p[2] & ~p[3];
            r[7:6] = r[12] ? p[5:4] : 2'b11;
         end
         STEP5: r[13] = c[12] & ~|p[3:0];
         STEP6: r[11:8] = c[13] ? p[3:0] : 4'hF;
         default: r = c;
      endcase
      return r;
   endfunction
   assign step_end  = div == DW'(STEP_DIV - 1);
   assign idle_done = idle_cnt == IW'(IDLE_STEPS - 1);
   assign n1 = scan(st, sc1, j1_s);
   assign n2 = scan(st, sc2, j2_s);
   always_comb
      nxt = st == IDLE ? (idle_done ? STEP0 : IDLE) : st == PUB ? IDLE : state_t'(st + 3'd1);
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         {j1_m, j1_s, j2_m, j2_s} <= '1;
         st         <= STEP0;
         div        <= '0;
         idle_cnt   <= '0;
         sc1        <= {2'b00, 12'hFFF};
         sc2        <= {2'b00, 12'hFFF};
         joy_sel_o  <= 1'b1;
         joy1_o     <= 12'hFFF;
         joy2_o     <= 12'hFFF;
         joy1_md_o  <= 1'b0;
         joy2_md_o  <= 1'b0;
         joy1_six_o <= 1'b0;
         joy2_six_o <= 1'b0;
         frame_o    <= 1'b0;
      end else begin
         {j1_m, j1_s, j2_m, j2_s} <= {joy1_i, j1_m, joy2_i, j2_m};
         div     <= step_end ? '0 : div + 1'b1;
         frame_o <= 1'b0;
         if (step_end) begin
            sc1       <= n1;
            sc2       <= n2;
            st        <= nxt;
            joy_sel_o <= !(nxt inside {STEP1, STEP3, STEP5});
            if (st == IDLE)
               idle_cnt <= idle_done ? '0 : idle_cnt + 1'b1;
            if (st == PUB) begin
               joy1_o     <= n1[11:0];
               joy2_o     <= n2[11:0];
               joy1_md_o  <= n1[12];
               joy2_md_o  <= n2[12];
               joy1_six_o <= n1[13];
               joy2_six_o <= n2[13];
               frame_o    <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_sega_joy_reader.sv
// tb_sega_joy_reader: directed bench with behavioural Master System / 3-button / 6-button pad models.
module tb_sega_joy_reader;
`ifdef SEGA_JOY_SIXBUTTON_EN
   localparam int FIRST = 28, PERIOD = 36, MID = 26;
   localparam logic [11:0] SIXW = 12'hBFF;
   localparam logic SIXF = 1'b1;
`else
   localparam int FIRST = 8, PERIOD = 16, MID = 14;
   localparam logic [11:0] SIXW = 12'hFFF;
   localparam logic SIXF = 1'b0;
`endif
   logic clk_sys = 0, reset = 1;
   logic [5:0] joy1_i, joy2_i;
   logic joy_sel_o, joy1_md_o, joy2_md_o, joy1_six_o, joy2_six_o, frame_o;
   logic [11:0] joy1_o, joy2_o;
   int kind1 = 0, kind2 = 0, cnt = 0, checks = 0, errors = 0, n;
   logic [11:0] btn1 = 12'hFFF, btn2 = 12'hFFF;
   logic sel_q;
   sega_joy_reader #(.STEP_DIV(4), .IDLE_STEPS(2)) dut (
      .clk_sys(clk_sys), .reset(reset), .joy1_i(joy1_i), .joy2_i(joy2_i),
      .joy_sel_o(joy_sel_o), .joy1_o(joy1_o), .joy2_o(joy2_o),
      .joy1_md_o(joy1_md_o), .joy2_md_o(joy2_md_o),
      .joy1_six_o(joy1_six_o), .joy2_six_o(joy2_six_o), .frame_o(frame_o));
   always #5 clk_sys = ~clk_sys;
   // kind: 0 none, 1 Master System, 2 three-button, 3 six-button; btn is the expected-format active-low word
   function automatic logic [5:0] pad(int kind, logic sel, int c, logic [11:0] b);
      if (kind == 0) return 6'h3F;
      if (kind == 1 || sel) return (kind == 3 && c == 3) ? {b[5:4], b[11:8]} : {b[5:4], b[3:0]};
      return {b[7:6], 2'b00, (kind == 3 && c == 3) ? 2'b00 : b[1:0]};
   endfunction
   assign joy1_i = pad(kind1, joy_sel_o, cnt, btn1);
   assign joy2_i = pad(kind2, joy_sel_o, cnt, btn2);
   // Select falling-edge counter, cleared by reset or publication (standing in for the pad timeout)
   always @(posedge clk_sys) begin
      if (reset || frame_o) cnt <= 0;
      else if (sel_q && !joy_sel_o) cnt <= cnt + 1;
      sel_q <= reset ? 1'b1 : joy_sel_o;
   end
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_frame(output int k);
      k = 0;
      do begin
         @(negedge clk_sys);
         k++;
      end while (!frame_o && k < 200);
   endtask
   initial begin
      repeat (3) @(negedge clk_sys);
      chk("rst_sel", joy_sel_o, 1);
      chk("rst_j1", joy1_o, 12'hFFF);
      chk("rst_j2", joy2_o, 12'hFFF);
      chk("rst_flags", {joy1_md_o, joy1_six_o, joy2_md_o, joy2_six_o}, 4'b0000);
      chk("rst_frame", frame_o, 0);
      kind1 = 1; btn1 = 12'hFFE;
      kind2 = 2; btn2 = 12'hFBF;
      reset = 0;
      wait_frame(n);
      chk("first_frame", n, FIRST);
      chk("ms_j1", joy1_o, 12'hFFE);
      chk("md3_j2", joy2_o, 12'hFBF);
      chk("ms_md3_flags", {joy1_md_o, joy1_six_o, joy2_md_o, joy2_six_o}, 4'b0010);
      @(negedge clk_sys);
      chk("frame_pulse", frame_o, 0);
      kind1 = 3; btn1 = 12'hBFF;
      kind2 = 0; btn2 = 12'hFFF;
      wait_frame(n);
      chk("period", n, PERIOD - 1);
      chk("six_j1", joy1_o, SIXW);
      chk("disc_j2", joy2_o, 12'hFFF);
      chk("six_flags", {joy1_md_o, joy1_six_o, joy2_md_o, joy2_six_o}, {1'b1, SIXF, 2'b00});
      repeat (MID) @(negedge clk_sys);
      reset = 1;
      #1;
      chk("async_j1", joy1_o, 12'hFFF);
      chk("async_j2", joy2_o, 12'hFFF);
      chk("async_flags", {joy1_md_o, joy1_six_o, joy2_md_o, joy2_six_o}, 4'b0000);
      chk("async_sel", joy_sel_o, 1);
      chk("async_frame", frame_o, 0);
      @(negedge clk_sys);
      reset = 0;
      wait_frame(n);
      chk("restart_frame", n, FIRST);
      chk("restart_j1", joy1_o, SIXW);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
